dmem_responder: RTL and testbench

Handshaked data-memory responder: the slave end of the core's load/store port. It accepts one word read or write request at a time over a valid/ready channel, inserts a configurable number of wait states, commits the access, and returns a response (read data or write acknowledge) over a second valid/ready channel. It replaces the zero-wait, unhandshaked data memory so the core's memory stage can be tested against realistic stall behaviour.

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channel pair between a load/store
// initiator (master) and the data-memory responder (slave).
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr              word index (not a byte address)
//   req_wdata             write data
//   resp_valid/resp_ready response handshake
//   resp_rdata            read data, 0 for writes
//   resp_err              address out of range (bounds-checked builds only)
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked single-outstanding data-memory responder.
// Accepts one word read/write, waits LATENCY cycles, commits the access and
// returns a response that is held until consumed.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset (clears memory, FSM and counter)
//   bus  dmem_responder_if.slave request/response channels
// Parameters:
//   DEPTH    number of 32-bit words
//   LATENCY  wait-state cycles between acceptance and response (0..15)
// Build option:
//   DMEM_BOUNDS_CHECK_EN  out-of-range addresses complete with resp_err=1,
//                         writes suppressed, reads return 0. Without it the
//                         address wraps modulo DEPTH (power of two required).
module dmem_responder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_COMMIT,
        S_RESP
    } state_t;

    state_t          state_q;
    state_t          next_state;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            accept;
    logic            commit;
    logic            release_resp;

    logic            req_ready_q;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [DW-1:0]   wdata_q;
    logic            err_q;
    logic            resp_valid_q;
    logic [DW-1:0]   resp_rdata_q;
    logic            resp_err_q;
    logic [DW-1:0]   mem [DEPTH];

    logic            addr_err_c;
    logic [AW-1:0]   addr_idx_c;

    assign addr_idx_c = bus.req_addr[AW-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_err_c = (bus.req_addr >= DW'(DEPTH));
`else
    // Upper address bits are discarded: the index wraps modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[DW-1:AW];
    assign addr_err_c     = 1'b0;
`endif

    // State and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= next_state;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and per-cycle strobes
    always_comb begin
        next_state   = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        commit       = 1'b0;
        release_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                // req_ready_q gates acceptance so the handshake the
                // initiator sees is exactly the one that is honoured.
                if (bus.req_valid && req_ready_q) begin
                    accept     = 1'b1;
                    cnt_d      = CW'(LATENCY);
                    next_state = (LATENCY == 0) ? S_COMMIT : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit     = 1'b1;
                next_state = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    release_resp = 1'b1;
                    next_state   = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, memory array and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            req_ready_q  <= 1'b0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= (next_state == S_IDLE);
            if (accept) begin
                we_q    <= bus.req_we;
                idx_q   <= addr_idx_c;
                wdata_q <= bus.req_wdata;
                err_q   <= addr_err_c;
            end
            if (commit) begin
                if (we_q && !err_q) begin
                    mem[idx_q] <= wdata_q;
                end
                resp_rdata_q <= (!we_q && !err_q) ? mem[idx_q] : '0;
                resp_err_q   <= err_q;
                resp_valid_q <= 1'b1;
            end else if (release_resp) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. Instance u_dut uses
// LATENCY=2, instance u_dut0 uses LATENCY=0; both DEPTH=32.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errs    = 0;

    always #5 clk = ~clk;

    dmem_responder_if b ();
    dmem_responder_if b0 ();

    dmem_responder #(.DEPTH(32), .LATENCY(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    dmem_responder #(.DEPTH(32), .LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; optional random resp_ready stalls.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic stall,
                       output logic [31:0] rdata, output logic err);
        int   n;
        int   lat;
        logic rr;
        logic [31:0] held;
        b.req_we    = we;
        b.req_addr  = addr;
        b.req_wdata = wdata;
        b.req_valid = 1'b1;
        n = 0;
        while (b.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_accept_timeout"}, 32'(n >= 50), 32'd0);
        @(posedge clk); #1;
        // Request fields are only sampled at acceptance; scramble them now.
        b.req_valid = 1'b0;
        b.req_we    = ~we;
        b.req_addr  = 32'h0000_0002;
        b.req_wdata = 32'hdead_beef;
        lat = 0;
        while (b.resp_valid !== 1'b1 && lat < 50) begin
            if (stall) b.resp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        rdata = b.resp_rdata;
        err   = b.resp_err;
        held  = b.resp_rdata;
        n = 0;
        do begin
            rr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n > 8) rr = 1'b1;
            b.resp_ready = rr;
            @(posedge clk); #1; n++;
            if (!rr) begin
                chk({tag, "_hold_valid"}, 32'(b.resp_valid), 32'd1);
                chk({tag, "_hold_rdata"}, b.resp_rdata, held);
            end
        end while (!rr);
        b.resp_ready = 1'b1;
        chk({tag, "_consumed"}, 32'(b.resp_valid), 32'd0);
        chk({tag, "_ready_again"}, 32'(b.req_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          n;
    logic [31:0] exp_seq [4];

    initial begin
        exp_seq[0] = 32'd10; exp_seq[1] = 32'd20; exp_seq[2] = 32'd50; exp_seq[3] = 32'd0;
        rst = 1'b1;
        b.req_valid = 1'b0;  b.req_we = 1'b0;  b.req_addr = '0;  b.req_wdata = '0;  b.resp_ready = 1'b1;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.resp_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(b.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(b.resp_valid), 32'd0);
        chk("rst_resp_rdata", b.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(b.resp_err), 32'd0);
        chk("rst_req_ready0", 32'(b0.req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_req_ready", 32'(b.req_ready), 32'd1);
        chk("post_rst_req_ready0", 32'(b0.req_ready), 32'd1);

        // Write then read
        txn("wr1", 1'b1, 32'd1, 32'd10, 1'b0, rd, er);
        chk("wr1_rdata", rd, 32'd0);
        chk("wr1_err", 32'(er), 32'd0);
        txn("rd1", 1'b0, 32'd1, 32'd0, 1'b0, rd, er);
        chk("rd1_rdata", rd, 32'd10);
        chk("rd1_err", 32'(er), 32'd0);

        // Zero-latency instance: response after acceptance edge + 1
        b0.req_we = 1'b1; b0.req_addr = 32'd6; b0.req_wdata = 32'd66; b0.req_valid = 1'b1;
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        chk("l0_ready_low", 32'(b0.req_ready), 32'd0);
        n = 0;
        while (b0.resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("l0_wr_latency", 32'(n), 32'd1);
        @(posedge clk); #1;
        chk("l0_consumed", 32'(b0.resp_valid), 32'd0);
        b0.req_we = 1'b0; b0.req_valid = 1'b1;
        @(posedge clk); #1;
        b0.req_valid = 1'b0;
        n = 0;
        while (b0.resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("l0_rd_latency", 32'(n), 32'd1);
        chk("l0_rd_rdata", b0.resp_rdata, 32'd66);
        @(posedge clk); #1;

        // Backpressure on a read of addr 3
        txn("wr3", 1'b1, 32'd3, 32'd50, 1'b0, rd, er);
        b.req_we = 1'b0; b.req_addr = 32'd3; b.req_valid = 1'b1;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        b.resp_ready = 1'b0;
        n = 0;
        while (b.resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_latency", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            b.req_valid = ~i[0];
            b.req_we    = 1'b1;
            b.req_addr  = 32'd5;
            b.req_wdata = 32'd77;
            @(posedge clk); #1;
            chk("bp_valid", 32'(b.resp_valid), 32'd1);
            chk("bp_rdata", b.resp_rdata, 32'd50);
            chk("bp_req_ready", 32'(b.req_ready), 32'd0);
        end
        b.req_valid = 1'b0;
        b.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 32'(b.resp_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_no_phantom", 32'(b.resp_valid), 32'd0);
        end
        txn("rd5", 1'b0, 32'd5, 32'd0, 1'b0, rd, er);
        chk("bp_addr5_untouched", rd, 32'd0);

        // Out-of-range address 40
        txn("wr40", 1'b1, 32'd40, 32'd7, 1'b0, rd, er);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("wr40_err", 32'(er), 32'd1);
`else
        chk("wr40_err", 32'(er), 32'd0);
`endif
        chk("wr40_rdata", rd, 32'd0);
        txn("rd40", 1'b0, 32'd40, 32'd0, 1'b0, rd, er);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("rd40_err", 32'(er), 32'd1);
        chk("rd40_rdata", rd, 32'd0);
`else
        chk("rd40_err", 32'(er), 32'd0);
        chk("rd40_rdata", rd, 32'd7);
`endif
        txn("rd8", 1'b0, 32'd8, 32'd0, 1'b0, rd, er);
        chk("rd8_err", 32'(er), 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("rd8_rdata", rd, 32'd0);
`else
        chk("rd8_rdata", rd, 32'd7);
`endif

        // Reset one cycle into BUSY of a write of 99 to addr 4
        b.req_we = 1'b1; b.req_addr = 32'd4; b.req_wdata = 32'd99; b.req_valid = 1'b1;
        @(posedge clk); #1;
        b.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(b.resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(b.req_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_resp", 32'(b.resp_valid), 32'd0);
        end
        txn("rd4_after_rst", 1'b0, 32'd4, 32'd0, 1'b0, rd, er);
        chk("rd4_after_rst_rdata", rd, 32'd0);
        txn("rd1_after_rst", 1'b0, 32'd1, 32'd0, 1'b0, rd, er);
        chk("rd1_after_rst_rdata", rd, 32'd0);

        // Sequence: write 1..4 then read back with random stalls
        for (int i = 0; i < 4; i++) begin
            txn("seq_wr", 1'b1, 32'(i + 1), exp_seq[i], 1'b1, rd, er);
            chk("seq_wr_rdata", rd, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            txn("seq_rd", 1'b0, 32'(i + 1), 32'd0, 1'b1, rd, er);
            chk("seq_rd_rdata", rd, exp_seq[i]);
            chk("seq_rd_err", 32'(er), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
